// File: rtl/qspi_mem_sched.sv
// rtl/qspi_mem_sched.sv - QSPI write sequencer and arbiter for the shared overlay/menu RAM port
module qspi_mem_sched #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_AW    = 3,
  parameter int STARVE_MAX = 16
) (
  input  logic              hClk,
  input  logic              hRst_n,
  input  logic              hdr_valid,
  input  logic              hdr_cmd,
  input  logic [9:0]        hdr_len,
  input  logic [31:0]       hdr_addr,
  input  logic              wd_valid,
  input  logic [15:0]       wd_data,
  input  logic              xfer_end,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              ovf,
  output logic              menu_init,
  output logic [9:0]        words_done
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCEPT  = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] base;
  logic [9:0]        remaining;
  logic [15:0]       fifo_mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr;
  logic [FIFO_AW:0]  rd_ptr;
  logic [FIFO_AW:0]  fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [SW-1:0]     starve_cnt;
  logic              starved;
  logic              wr_sel;
  logic              word_in;
  logic              push;
  logic              drop;
  logic              hdr_write;
  logic              hdr_in_win;
  logic [1:0]        menu_chain;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[FIFO_AW];
  assign starved    = (starve_cnt == SW'(STARVE_MAX));

  // Reads win unless the pending write has waited STARVE_MAX cycles.
  assign wr_sel    = !fifo_empty && (!rd_req || starved);
  assign rd_gnt    = rd_req && !wr_sel;
  assign mem_en    = rd_gnt || wr_sel;
  assign mem_we    = wr_sel;
  assign mem_addr  = wr_sel ? (base + ADDR_W'(words_done)) : rd_addr;
  assign mem_wdata = wr_sel ? fifo_mem[rd_ptr[FIFO_AW-1:0]] : 16'h0000;

  assign word_in    = (state == ST_ACCEPT) && wd_valid && (remaining != 10'd0);
  assign push       = word_in && (!fifo_full || wr_sel);
  assign drop       = word_in && fifo_full && !wr_sel;
  assign hdr_write  = (state == ST_IDLE) && hdr_valid && !hdr_cmd && (hdr_len != 10'd0);
  assign hdr_in_win = (hdr_addr[31:ADDR_W+1] == '0);

  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign menu_init = menu_chain[1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (hdr_write) state_nxt = hdr_in_win ? ST_ACCEPT : ST_DISCARD;
      end
      ST_ACCEPT: begin
        if (xfer_end || (word_in && remaining == 10'd1)) state_nxt = ST_DRAIN;
      end
      ST_DISCARD: begin
        if (xfer_end) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        // Leave as the last word is written so busy drops right after it.
        if (fifo_empty || (fifo_cnt == (FIFO_AW+1)'(1) && wr_sel)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hClk or negedge hRst_n) begin
    if (!hRst_n) begin
      state      <= ST_IDLE;
      base       <= '0;
      remaining  <= '0;
      words_done <= '0;
      ovf        <= 1'b0;
      menu_chain <= 2'b00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_gnt;
      rd_data  <= mem_rdata;

      if (hdr_write && hdr_in_win) begin
        base       <= hdr_addr[ADDR_W:1];
        remaining  <= hdr_len;
        words_done <= '0;
        ovf        <= 1'b0;
        if (hdr_addr == 32'h0) menu_chain <= {menu_chain[0], 1'b1};
      end else begin
        if (word_in) remaining <= remaining - 10'd1;
        if (drop) ovf <= 1'b1;
        if (wr_sel && words_done != 10'h3FF) words_done <= words_done + 10'd1;
      end

      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (wr_sel) rd_ptr <= rd_ptr + 1'b1;

      if (wr_sel)                       starve_cnt <= '0;
      else if (!fifo_empty && rd_req)   starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge hClk) begin
    if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= wd_data;
  end

endmodule

// File: tb/tb_qspi_mem_sched.sv
// tb/tb_qspi_mem_sched.sv - directed self-checking bench for qspi_mem_sched
module tb_qspi_mem_sched;

  localparam int ADDR_W     = 17;
  localparam int STARVE_MAX = 16;

  logic              hClk;
  logic              hRst_n;
  logic              hdr_valid;
  logic              hdr_cmd;
  logic [9:0]        hdr_len;
  logic [31:0]       hdr_addr;
  logic              wd_valid;
  logic [15:0]       wd_data;
  logic              xfer_end;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              busy;
  logic              ovf;
  logic              menu_init;
  logic [9:0]        words_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [15:0]       wd_q[$];
  int                wc_q[$];
  logic              wg_q[$];

  qspi_mem_sched #(.ADDR_W(ADDR_W), .FIFO_AW(3), .STARVE_MAX(STARVE_MAX)) dut (
    .hClk(hClk), .hRst_n(hRst_n),
    .hdr_valid(hdr_valid), .hdr_cmd(hdr_cmd), .hdr_len(hdr_len), .hdr_addr(hdr_addr),
    .wd_valid(wd_valid), .wd_data(wd_data), .xfer_end(xfer_end),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .ovf(ovf), .menu_init(menu_init),
    .words_done(words_done)
  );

  initial hClk = 1'b0;
  always #5 hClk = ~hClk;

  always @(posedge hClk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[15:0] ^ 16'h5A5A;
  end

  always @(negedge hClk) begin
    cyc++;
    if (hRst_n && mem_en && mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      wg_q.push_back(rd_gnt);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish before 300000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge hClk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    wg_q.delete();
  endtask

  task automatic send_hdr(input logic cmd, input logic [9:0] len, input logic [31:0] addr);
    hdr_valid = 1'b1;
    hdr_cmd   = cmd;
    hdr_len   = len;
    hdr_addr  = addr;
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic last);
    wd_valid = 1'b1;
    wd_data  = d;
    xfer_end = last;
    tick();
    wd_valid = 1'b0;
    xfer_end = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge hClk);
      if (wa_q.size() >= n) break;
    end
    #1;
    check(tag, wa_q.size(), n);
  endtask

  initial begin
    hRst_n = 1'b0; hdr_valid = 1'b0; hdr_cmd = 1'b0; hdr_len = '0; hdr_addr = '0;
    wd_valid = 1'b0; wd_data = '0; xfer_end = 1'b0; rd_req = 1'b0; rd_addr = 17'h01234;
    mem_rdata = '0;

    @(negedge hClk);
    check("rst_mem_en", mem_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_menu_init", menu_init, 0);
    check("rst_words_done", words_done, 0);
    tick();
    hRst_n = 1'b1;
    tick();

    // reset while three words sit in the FIFO behind a reader
    rd_req = 1'b1;
    send_hdr(1'b0, 10'd4, 32'h100);
    for (int i = 0; i < 3; i++) send_word(16'h1111 * (i + 1), 1'b0);
    @(negedge hClk);
    check("t1_busy_pre", busy, 1);
    check("t1_rd_gnt_pre", rd_gnt, 1);
    check("t1_we_pre", mem_we, 0);
    tick();
    hRst_n = 1'b0;
    rd_req = 1'b0;
    @(negedge hClk);
    check("t1_mem_en", mem_en, 0);
    check("t1_busy", busy, 0);
    check("t1_words_done", words_done, 0);
    tick();
    hRst_n = 1'b1;
    repeat (4) tick();
    check("t1_no_writes", wa_q.size(), 0);
    check("t1_busy_after", busy, 0);

    // plain 4-word transfer, plus a fifth word arriving after the count ran out
    clear_log();
    send_hdr(1'b0, 10'd4, 32'h100);
    for (int i = 0; i < 5; i++) send_word(16'h1111 * (i + 1), 1'b0);
    wait_writes("t2_nwrites", 4);
    @(negedge hClk);
    check("t2_busy_done", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_addr%0d", i), wa_q[i], 17'h80 + i);
      check($sformatf("t2_data%0d", i), wd_q[i], 16'h1111 * (i + 1));
    end
    check("t2_words_done", words_done, 4);
    check("t2_ovf", ovf, 0);
    repeat (3) tick();
    check("t2_no_extra", wa_q.size(), 4);

    // same transfer against a continuous reader
    clear_log();
    rd_req = 1'b1;
    send_hdr(1'b0, 10'd4, 32'h100);
    for (int i = 0; i < 4; i++) send_word(16'h1111 * (i + 1), 1'b0);
    @(negedge hClk);
    check("t3_rd_valid", rd_valid, 1);
    wait_writes("t3_nwrites", 4);
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_addr%0d", i), wa_q[i], 17'h80 + i);
      check($sformatf("t3_data%0d", i), wd_q[i], 16'h1111 * (i + 1));
      check($sformatf("t3_gnt%0d", i), wg_q[i], 0);
      if (i > 0) check($sformatf("t3_gap%0d", i), wc_q[i] - wc_q[i-1], STARVE_MAX + 1);
    end
    repeat (3) tick();
    check("t3_ovf", ovf, 0);
    check("t3_words_done", words_done, 4);
    check("t3_busy", busy, 0);

    // overflow: ten words into an eight-deep FIFO while reads dominate
    clear_log();
    rd_req = 1'b1;
    send_hdr(1'b0, 10'd10, 32'h200);
    for (int i = 0; i < 10; i++) send_word(16'hA000 + i, 1'b0);
    repeat (9) tick();
    rd_req = 1'b0;
    wait_writes("t4_nwrites", 8);
    repeat (3) tick();
    check("t4_ovf", ovf, 1);
    check("t4_words_done", words_done, 8);
    check("t4_total", wa_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_addr%0d", i), wa_q[i], 17'h100 + i);
      check($sformatf("t4_data%0d", i), wd_q[i], 16'hA000 + i);
    end

    // address wrap at the top of the window
    clear_log();
    send_hdr(1'b0, 10'd2, 32'h0003_FFFE);
    send_word(16'hBEEF, 1'b0);
    send_word(16'hCAFE, 1'b0);
    wait_writes("t5_nwrites", 2);
    check("t5_addr0", wa_q[0], 17'h1FFFF);
    check("t5_addr1", wa_q[1], 17'h00000);
    check("t5_data1", wd_q[1], 16'hCAFE);
    check("t5_ovf_cleared", ovf, 0);

    // menu init after the second header to address 0
    clear_log();
    send_hdr(1'b0, 10'd1, 32'h0);
    send_word(16'h0101, 1'b0);
    wait_writes("t6_first", 1);
    tick();
    check("t6_menu_first", menu_init, 0);
    send_hdr(1'b0, 10'd1, 32'h0);
    send_word(16'h0202, 1'b0);
    wait_writes("t6_second", 2);
    tick();
    check("t6_menu_second", menu_init, 1);

    // out-of-window header swallows its words
    clear_log();
    send_hdr(1'b0, 10'd2, 32'h0004_0000);
    send_word(16'hDEAD, 1'b0);
    @(negedge hClk);
    check("t6_discard_busy", busy, 1);
    send_word(16'hDEAD, 1'b0);
    xfer_end = 1'b1;
    tick();
    xfer_end = 1'b0;
    @(negedge hClk);
    check("t6_discard_idle", busy, 0);
    repeat (3) tick();
    check("t6_discard_nowrites", wa_q.size(), 0);
    check("t6_menu_sticky", menu_init, 1);

    // read header ignored; early xfer_end together with the last word
    clear_log();
    send_hdr(1'b1, 10'd4, 32'h100);
    @(negedge hClk);
    check("t7_read_hdr_idle", busy, 0);
    send_hdr(1'b0, 10'd4, 32'h300);
    send_word(16'h7001, 1'b0);
    send_word(16'h7002, 1'b1);
    wait_writes("t7_nwrites", 2);
    repeat (3) tick();
    check("t7_total", wa_q.size(), 2);
    check("t7_addr1", wa_q[1], 17'h181);
    check("t7_data1", wd_q[1], 16'h7002);
    check("t7_words_done", words_done, 2);
    check("t7_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
